// File: rtl/fp_sequencer.sv
// Forward-propagation sequencer: walks every sample through all hidden neurons,
// then one output-layer job, with a per-job watchdog and synchronous abort.
module fp_sequencer #(
   parameter int ROWS    = 100,
   parameter int NEURONS = 10,
   parameter int TIMEOUT = 4096,
   parameter int SW      = 7,
   parameter int NW      = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic          act1_start,
   input  logic          act1_done,
   output logic          act2_start,
   input  logic          act2_done,
   output logic [SW-1:0] sample_idx,
   output logic          layer_idx,
   output logic [NW-1:0] neuron_idx,
   output logic          busy,
   output logic          done_fp,
   output logic          err
);

   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {IDLE, H_ISSUE, H_WAIT, O_ISSUE, O_WAIT, DONE, ERR} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] sample_q, sample_d;
   logic [NW-1:0] neuron_q, neuron_d;
   logic          layer_q, layer_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          wd_exp;

   assign wd_exp = (wd_q == WW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sample_q <= '0;
         neuron_q <= '0;
         layer_q  <= 1'b0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         neuron_q <= neuron_d;
         layer_q  <= layer_d;
         wd_q     <= wd_d;
      end
   end

   // Watchdog defaults to clear, so every ISSUE cycle restarts it for the next wait.
   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      neuron_d = neuron_q;
      layer_d  = layer_q;
      wd_d     = '0;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d  = H_ISSUE;
               sample_d = '0;
               neuron_d = '0;
               layer_d  = 1'b0;
            end
         end
         H_ISSUE: begin
            layer_d = 1'b0;
            state_d = H_WAIT;
         end
         H_WAIT: begin
            wd_d = wd_q + 1'b1;
            if (act1_done) begin
               if (neuron_q == NW'(NEURONS - 1)) begin
                  neuron_d = '0;
                  layer_d  = 1'b1;
                  state_d  = O_ISSUE;
               end else begin
                  neuron_d = neuron_q + 1'b1;
                  state_d  = H_ISSUE;
               end
            end else if (wd_exp) begin
               state_d = ERR;
            end
         end
         O_ISSUE: state_d = O_WAIT;
         O_WAIT: begin
            wd_d = wd_q + 1'b1;
            if (act2_done) begin
               if (sample_q == SW'(ROWS - 1)) begin
                  state_d = DONE;
               end else begin
                  sample_d = sample_q + 1'b1;
                  layer_d  = 1'b0;
                  state_d  = H_ISSUE;
               end
            end else if (wd_exp) begin
               state_d = ERR;
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort overrides any done accepted in the same cycle.
      if (abort && busy) begin
         state_d  = IDLE;
         sample_d = '0;
         neuron_d = '0;
         layer_d  = 1'b0;
         wd_d     = '0;
      end
   end

   assign busy       = (state_q == H_ISSUE) || (state_q == H_WAIT) ||
                       (state_q == O_ISSUE) || (state_q == O_WAIT);
   assign act1_start = (state_q == H_ISSUE);
   assign act2_start = (state_q == O_ISSUE);
   assign done_fp    = (state_q == DONE);
   assign err        = (state_q == ERR);
   assign sample_idx = sample_q;
   assign neuron_idx = neuron_q;
   assign layer_idx  = layer_q;

endmodule
